mem_dcache_access: RTL and testbench
====================================

// Module: mem_dcache_access
// PURPOSE
// - Reader side of the EXE->MEM pipeline register. Consumes the MEM-stage fields
//   (address, store data, load/store type) and runs one data-cache transaction per memory instruction.
// - Issues a valid/ready request, waits for the load response, and formats/extends load data for WB.
// - Holds the pipeline (MEM_Stall) until the access is complete.
// PARAMETERS
// - ADDR_W   32  request address width
// - DATA_W   32  data width; only 32 is supported
// PORTS
// - clk            in   1   clock, rising edge
// - rst            in   1   reset, asynchronous, active-high
// - MEM_Flush      in   1   kill the instruction currently in MEM
// - WB_Wr          in   1   MEM->WB register accepts this cycle
// - MEM_ALUOut     in   32  effective address
// - MEM_OutB       in   32  store data (rt)
// - MEM_LoadType   in   3   NONE/LB/LBU/LH/LHU/LW (CPU_Defines enum)
// - MEM_StoreType  in   2   NONE/SB/SH/SW (CPU_Defines enum)
// - dc_req_valid   out  1   request valid (registered)
// - dc_req_ready   in   1   cache accepts request
// - dc_req_wr      out  1   1 = store
// - dc_req_addr    out  32  word-aligned address {addr[31:2],2'b00}
// - dc_req_wstrb   out  4   byte enables (stores); 4'b1111 for loads
// - dc_req_wdata   out  32  lane-aligned store data
// - dc_resp_valid  in   1   load data valid, one-cycle pulse
// - dc_resp_rdata  in   32  raw word from cache
// - MEM_Stall      out  1   hold EXE->MEM and earlier stages
// - MEM_LoadData   out  32  formatted load result, valid in DONE
// - MEM_AdExc      out  1   address error (only with MEM_ADDR_CHECK_EN)
// BEHAVIOUR
// - Reset values: state=IDLE, kill=0; dc_req_valid, dc_req_wr, dc_req_addr, dc_req_wstrb,
//   dc_req_wdata, MEM_LoadData, MEM_AdExc all 0. MEM_Stall=0 because no op is present.
// - op_present = (MEM_LoadType!=NONE) | (MEM_StoreType!=NONE).
// - FSM IDLE/REQ/WAIT/DONE:
//   - IDLE: if op_present & !MEM_Flush, latch addr/wstrb/wdata/type, then go to REQ.
//   - REQ: dc_req_valid=1; fields stay stable until dc_req_ready.
//     - On handshake a store goes to DONE and a load goes to WAIT.
//   - WAIT: on dc_resp_valid, register the formatted data into MEM_LoadData, then go to DONE.
//   - DONE: on WB_Wr or MEM_Flush, go to IDLE.
// - MEM_Stall = (op_present & state!=DONE) | kill. Stall is combinational from state.
// - Latency with ready/resp zero-wait:
//   - Store: IDLE, REQ, then DONE in cycle 2.
//   - Load: IDLE, REQ, WAIT(resp), then DONE in cycle 3.
// - Once asserted, dc_req_valid never drops before the handshake.
// - Flush:
//   - In IDLE or DONE: go to IDLE immediately.
//   - In REQ or WAIT: set kill. The transaction completes, load data is discarded and
//     MEM_LoadData is not updated. Then go to IDLE and clear kill.
//   - MEM_Stall stays 1 while kill=1, so a new op cannot issue before the drain.
// - Store lanes:
//   - SB: wstrb=1<<a[1:0]; wdata=byte replicated to all 4 lanes.
//   - SH: wstrb = a[1] ? 4'b1100 : 4'b0011; wdata=halfword replicated.
//   - SW: wstrb=4'b1111.
// - Load format: byte select by a[1:0], half select by a[1]. LB/LH sign-extend; LBU/LHU zero-extend.
// - Simultaneous WB_Wr and MEM_Flush in DONE: go to IDLE (same result either way).
// - rst asserted mid-transaction: immediate return to IDLE, valid dropped. The cache must be reset together with this block.
// CONFIGURATION
// - MEM_ADDR_CHECK_EN defined:
//   - Misaligned LH/LHU/SH (a[0]) or LW/SW (a[1:0]!=0) issues no request. IDLE goes directly to DONE.
//   - MEM_AdExc=1 while in DONE.
// - MEM_ADDR_CHECK_EN undefined:
//   - Low address bits below access size are ignored (access treated as aligned).
//   - MEM_AdExc is tied to 0.
// STRUCTURE
// - CPU_Defines package: LoadType/StoreType enums and the MemAccState_t enum {IDLE,REQ,WAIT,DONE}.
// - One sub-module, mem_load_formatter (combinational): raw word + a[1:0] + LoadType -> 32-bit result.
// - The FSM, lane logic and output registers stay in mem_dcache_access.
// TESTING
// - SW, a=0x100, d=0xDEADBEEF, ready=1 -> req addr 0x100, wstrb 1111; MEM_Stall high 2 cycles; DONE in cycle 2.
// - LB, a=0x103, rdata=0x80FF1234, resp 1 cycle after handshake -> MEM_LoadData=0xFFFFFF80.
// - LHU, a=0x102, rdata=0x80FF1234, ready low 3 cycles -> dc_req_valid and fields held stable; data=0x000080FF.
// - SB, a=0x201, d=0x000000AB -> wstrb=0010, wdata=0xABABABAB.
// - MEM_Flush during WAIT -> MEM_Stall held until resp; MEM_LoadData unchanged; next op issues only after IDLE.
// - MEM_ADDR_CHECK_EN, LW a=0x302 -> no dc_req_valid; MEM_AdExc=1 in the following cycle; stall drops.

Source files
------------

// File: rtl/mem_dcache_access_pkg.sv
// Shared CPU encodings for the MEM stage: load/store types, the data-cache
// access FSM states, and an alignment helper.
package CPU_Defines;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5
    } LoadType_t;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } StoreType_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } MemAccState_t;

    // Halfword ops need a[0]==0, word ops need a[1:0]==0; byte ops never trap.
    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] st,
                                           input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (lt == LT_LH) || (lt == LT_LHU) || (st == ST_SH);
        word_op = (lt == LT_LW) || (st == ST_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_dcache_access_formatter.sv
// Combinational load formatter: selects the byte/halfword addressed by the low
// address bits and sign- or zero-extends it according to the load type.
module mem_load_formatter
    import CPU_Defines::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_ltype,
    output logic [31:0] o_data
);

    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[i_off];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_ltype)
            LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_data = {24'd0, w_byte};
            LT_LH:   o_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_dcache_access.sv
// MEM-stage data-cache access: one valid/ready request per memory op, load
// formatting and pipeline stall. Define MEM_ADDR_CHECK_EN to trap misaligned accesses.
module mem_dcache_access
    import CPU_Defines::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_Flush,
    input  logic              WB_Wr,
    input  logic [ADDR_W-1:0] MEM_ALUOut,
    input  logic [DATA_W-1:0] MEM_OutB,
    input  logic [2:0]        MEM_LoadType,
    input  logic [1:0]        MEM_StoreType,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_wr,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [3:0]        dc_req_wstrb,
    output logic [DATA_W-1:0] dc_req_wdata,
    input  logic              dc_resp_valid,
    input  logic [DATA_W-1:0] dc_resp_rdata,
    output logic              MEM_Stall,
    output logic [DATA_W-1:0] MEM_LoadData,
    output logic              MEM_AdExc
);

    MemAccState_t      r_state;
    MemAccState_t      w_state_next;
    logic              r_kill;
    logic              w_kill_next;
    logic              r_req_valid;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ltype;
    logic [DATA_W-1:0] r_load_data;

    logic              w_op_present;
    logic              w_is_store;
    logic              w_misal;
    logic              w_accept;
    logic              w_drop;
    logic [3:0]        w_sb_strb;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_fmt_data;

    assign w_op_present = (MEM_LoadType != LT_NONE) || (MEM_StoreType != ST_NONE);
    assign w_is_store   = (MEM_StoreType != ST_NONE);
    assign w_accept     = (r_state == IDLE) && w_op_present && !MEM_Flush;
    // A flush seen while the cache is busy lets the access finish, then drops it.
    assign w_drop       = r_kill || MEM_Flush;

`ifdef MEM_ADDR_CHECK_EN
    assign w_misal = is_misaligned(MEM_LoadType, MEM_StoreType, MEM_ALUOut[1:0]);
`else
    assign w_misal = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sb_strb
            assign w_sb_strb[gi] = (MEM_ALUOut[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = '0;
        case (MEM_StoreType)
            ST_SB: begin
                w_wstrb = w_sb_strb;
                w_wdata = {4{MEM_OutB[7:0]}};
            end
            ST_SH: begin
                w_wstrb = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MEM_OutB[15:0]}};
            end
            ST_SW:   w_wdata = MEM_OutB;
            default: w_wdata = '0;
        endcase
    end

    mem_load_formatter u_fmt (
        .i_rdata (dc_resp_rdata),
        .i_off   (r_off),
        .i_ltype (r_ltype),
        .o_data  (w_fmt_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_misal ? DONE : REQ;
            REQ:  if (dc_req_ready) w_state_next = !r_wr ? WAIT : (w_drop ? IDLE : DONE);
            WAIT: if (dc_resp_valid) w_state_next = w_drop ? IDLE : DONE;
            DONE: if (WB_Wr || MEM_Flush) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_kill_next = ((r_state == REQ) || (r_state == WAIT)) && w_drop && (w_state_next != IDLE);
    end

    always_comb begin
        MEM_Stall = (w_op_present && (r_state != DONE)) || r_kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_off       <= 2'b00;
            r_wstrb     <= 4'b0000;
            r_wdata     <= '0;
            r_ltype     <= LT_NONE;
            r_load_data <= '0;
        end else begin
            r_req_valid <= (w_state_next == REQ);
            if (w_accept) begin
                r_wr    <= w_is_store;
                r_addr  <= {MEM_ALUOut[ADDR_W-1:2], 2'b00};
                r_off   <= MEM_ALUOut[1:0];
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
                r_ltype <= MEM_LoadType;
            end
            if ((r_state == WAIT) && dc_resp_valid && !w_drop) begin
                r_load_data <= w_fmt_data;
            end
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic r_misal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misal <= 1'b0;
        end else if (w_accept) begin
            r_misal <= w_misal;
        end
    end

    assign MEM_AdExc = r_misal && (r_state == DONE);
`else
    assign MEM_AdExc = 1'b0;
`endif

    assign dc_req_valid = r_req_valid;
    assign dc_req_wr    = r_wr;
    assign dc_req_addr  = r_addr;
    assign dc_req_wstrb = r_wstrb;
    assign dc_req_wdata = r_wdata;
    assign MEM_LoadData = r_load_data;

endmodule

// File: tb/tb_mem_dcache_access.sv
// Self-checking bench for mem_dcache_access: directed scenarios plus randomized
// loads/stores against an arithmetic reference model of lanes and load extension.
module tb_mem_dcache_access;
    import CPU_Defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Flush, WB_Wr;
    logic [31:0] MEM_ALUOut, MEM_OutB;
    logic [2:0]  MEM_LoadType;
    logic [1:0]  MEM_StoreType;
    logic        dc_req_valid, dc_req_ready, dc_req_wr;
    logic [31:0] dc_req_addr, dc_req_wdata;
    logic [3:0]  dc_req_wstrb;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_rdata;
    logic        MEM_Stall, MEM_AdExc;
    logic [31:0] MEM_LoadData;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_last_load;

    typedef struct {
        int          stall_cycles;
        int          valid_cycles;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] ld;
        logic        adexc;
        logic        stable;
    } obs_t;

    always #5 clk = ~clk;

    mem_dcache_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .MEM_Flush(MEM_Flush), .WB_Wr(WB_Wr),
        .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
        .MEM_LoadType(MEM_LoadType), .MEM_StoreType(MEM_StoreType),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_wr(dc_req_wr),
        .dc_req_addr(dc_req_addr), .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .MEM_Stall(MEM_Stall), .MEM_LoadData(MEM_LoadData), .MEM_AdExc(MEM_AdExc)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_wstrb(input logic [1:0] st, input logic [31:0] a);
        if (st == ST_SB) return 4'(1 << (a % 4));
        if (st == ST_SH) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] st, input logic [31:0] d);
        if (st == ST_SB) return (d & 32'hFF) * 32'h0101_0101;
        if (st == ST_SH) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * (a % 4))) & 32'hFF;
        h = (raw >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (lt)
            LT_LB:   return (b >= 128) ? b - 32'd256 : b;
            LT_LBU:  return b;
            LT_LH:   return (h >= 32768) ? h - 32'd65536 : h;
            LT_LHU:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic ref_misal(input logic [2:0] lt, input logic [1:0] st,
                                       input logic [31:0] a);
        int size;
        size = 1;
        if (lt == LT_LH || lt == LT_LHU || st == ST_SH) size = 2;
        if (lt == LT_LW || st == ST_SW) size = 4;
        return (a % size) != 0;
    endfunction

    // Runs one op through the cache handshake and reports what was observed.
    task automatic drive_op(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] raw,
                            input int rdy_wait, input int resp_wait, output obs_t o);
        int   rdy_cnt, resp_cnt;
        logic hs;
        o.stall_cycles = 0; o.valid_cycles = 0; o.stable = 1'b1;
        o.addr = '0; o.strb = '0; o.wdata = '0; o.wr = 1'b0; o.ld = '0; o.adexc = 1'b0;
        rdy_cnt = 0; resp_cnt = 0; hs = 1'b0;
        @(negedge clk);
        MEM_LoadType = lt; MEM_StoreType = st; MEM_ALUOut = a; MEM_OutB = d;
        WB_Wr = 1'b0; MEM_Flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        o.stall_cycles = 60;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (!MEM_Stall) begin
                o.stall_cycles = cyc;
                o.ld = MEM_LoadData;
                o.adexc = MEM_AdExc;
                break;
            end
            dc_req_ready = 1'b0;
            dc_resp_valid = 1'b0;
            dc_resp_rdata = ~raw;
            if (dc_req_valid) begin
                if (o.valid_cycles == 0) begin
                    o.addr = dc_req_addr; o.strb = dc_req_wstrb;
                    o.wdata = dc_req_wdata; o.wr = dc_req_wr;
                end else if (o.addr !== dc_req_addr || o.strb !== dc_req_wstrb ||
                             o.wdata !== dc_req_wdata || o.wr !== dc_req_wr) begin
                    o.stable = 1'b0;
                end
                o.valid_cycles++;
                if (rdy_cnt >= rdy_wait) begin
                    dc_req_ready = 1'b1;
                    hs = 1'b1;
                end else begin
                    rdy_cnt++;
                end
            end else if (o.valid_cycles > 0 && !hs) begin
                o.stable = 1'b0;
            end else if (hs) begin
                if (resp_cnt >= resp_wait) begin
                    dc_resp_valid = 1'b1;
                    dc_resp_rdata = raw;
                end else begin
                    resp_cnt++;
                end
            end
            @(negedge clk);
        end
        WB_Wr = 1'b1; MEM_LoadType = LT_NONE; MEM_StoreType = ST_NONE;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        @(negedge clk);
        WB_Wr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; MEM_Flush = 0; WB_Wr = 0; MEM_ALUOut = 0; MEM_OutB = 0;
        MEM_LoadType = LT_NONE; MEM_StoreType = ST_NONE;
        dc_req_ready = 0; dc_resp_valid = 0; dc_resp_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if ({dc_req_valid, dc_req_wr, MEM_Stall, MEM_AdExc} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {dc_req_valid, dc_req_wr, MEM_Stall, MEM_AdExc}); end
        checks++; if ({dc_req_addr, dc_req_wstrb, dc_req_wdata} !== 68'd0) begin
            failures++; $display("FAIL reset_req got=%h/%b/%h exp=0", dc_req_addr, dc_req_wstrb, dc_req_wdata); end
        checks++; if (MEM_LoadData !== 32'd0) begin
            failures++; $display("FAIL reset_loaddata got=%h exp=0", MEM_LoadData); end
        exp_last_load = 32'd0;
    endtask

    task automatic test_store_word();
        obs_t o;
        drive_op(3'(LT_NONE), 2'(ST_SW), 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, o);
        $display("txn sw addr=%h strb=%b wdata=%h stall=%0d", o.addr, o.strb, o.wdata, o.stall_cycles);
        checks++; if (o.addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", o.addr); end
        checks++; if (o.strb !== 4'b1111) begin failures++; $display("FAIL sw_strb got=%b exp=1111", o.strb); end
        checks++; if (o.wdata !== 32'hDEADBEEF || o.wr !== 1'b1) begin
            failures++; $display("FAIL sw_data got=%h wr=%b exp=deadbeef wr=1", o.wdata, o.wr); end
        checks++; if (o.stall_cycles !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", o.stall_cycles); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        drive_op(3'(LT_LB), 2'(ST_NONE), 32'h103, 32'h0, 32'h80FF1234, 0, 0, o);
        $display("txn lb addr=%h data=%h stall=%0d", o.addr, o.ld, o.stall_cycles);
        checks++; if (o.ld !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", o.ld); end
        checks++; if (o.addr !== 32'h100 || o.strb !== 4'hF || o.wr !== 1'b0) begin
            failures++; $display("FAIL lb_req got=%h/%b/%b exp=00000100/1111/0", o.addr, o.strb, o.wr); end
        checks++; if (o.stall_cycles !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", o.stall_cycles); end
        exp_last_load = 32'hFFFFFF80;
    endtask

    task automatic test_ready_stall();
        obs_t o;
        drive_op(3'(LT_LHU), 2'(ST_NONE), 32'h102, 32'h0, 32'h80FF1234, 3, 0, o);
        $display("txn lhu addr=%h data=%h valid_cycles=%0d", o.addr, o.ld, o.valid_cycles);
        checks++; if (o.stable !== 1'b1 || o.valid_cycles !== 4) begin
            failures++; $display("FAIL lhu_hold got stable=%b valid=%0d exp stable=1 valid=4", o.stable, o.valid_cycles); end
        checks++; if (o.ld !== 32'h000080FF) begin failures++; $display("FAIL lhu_data got=%h exp=000080ff", o.ld); end
        checks++; if (o.stall_cycles !== 6) begin failures++; $display("FAIL lhu_latency got=%0d exp=6", o.stall_cycles); end
        exp_last_load = 32'h000080FF;
    endtask

    task automatic test_store_byte();
        obs_t o;
        drive_op(3'(LT_NONE), 2'(ST_SB), 32'h201, 32'h000000AB, 32'h0, 1, 0, o);
        $display("txn sb addr=%h strb=%b wdata=%h", o.addr, o.strb, o.wdata);
        checks++; if (o.strb !== 4'b0010) begin failures++; $display("FAIL sb_strb got=%b exp=0010", o.strb); end
        checks++; if (o.wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", o.wdata); end
        checks++; if (o.addr !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=00000200", o.addr); end
    endtask

    task automatic test_addr_check();
        obs_t o;
        drive_op(3'(LT_LW), 2'(ST_NONE), 32'h302, 32'h0, 32'hCAFEF00D, 0, 0, o);
        $display("txn lw_misal valid_cycles=%0d adexc=%b stall=%0d", o.valid_cycles, o.adexc, o.stall_cycles);
`ifdef MEM_ADDR_CHECK_EN
        checks++; if (o.valid_cycles !== 0) begin failures++; $display("FAIL adexc_noreq got=%0d exp=0", o.valid_cycles); end
        checks++; if (o.adexc !== 1'b1 || o.stall_cycles !== 1) begin
            failures++; $display("FAIL adexc_flag got adexc=%b stall=%0d exp adexc=1 stall=1", o.adexc, o.stall_cycles); end
        checks++; if (o.ld !== exp_last_load) begin failures++; $display("FAIL adexc_data got=%h exp=%h", o.ld, exp_last_load); end
`else
        checks++; if (o.addr !== 32'h300 || o.valid_cycles !== 1) begin
            failures++; $display("FAIL lw_align got=%h valid=%0d exp=00000300 valid=1", o.addr, o.valid_cycles); end
        checks++; if (o.ld !== 32'hCAFEF00D || o.adexc !== 1'b0) begin
            failures++; $display("FAIL lw_align_data got=%h adexc=%b exp=cafef00d adexc=0", o.ld, o.adexc); end
        exp_last_load = 32'hCAFEF00D;
`endif
    endtask

    task automatic test_flush_wait();
        @(negedge clk);
        MEM_LoadType = LT_LW; MEM_StoreType = ST_NONE; MEM_ALUOut = 32'h400; dc_req_ready = 1'b1;
        @(negedge clk);                       // REQ, handshake at next edge
        @(negedge clk);                       // WAIT
        dc_req_ready = 1'b0; MEM_Flush = 1'b1;
        @(negedge clk);                       // killed, new op waits behind the drain
        MEM_Flush = 1'b0;
        MEM_LoadType = LT_NONE; MEM_StoreType = ST_SW; MEM_ALUOut = 32'h500; MEM_OutB = 32'h5A5A0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (MEM_Stall !== 1'b1 || dc_req_valid !== 1'b0) begin
                failures++; $display("FAIL flush_drain[%0d] got stall=%b valid=%b exp stall=1 valid=0", i, MEM_Stall, dc_req_valid); end
            if (i == 1) begin dc_resp_valid = 1'b1; dc_resp_rdata = 32'h12345678; end
            @(negedge clk);
        end
        dc_resp_valid = 1'b0;
        #1;
        checks++; if (MEM_LoadData !== exp_last_load) begin
            failures++; $display("FAIL flush_loaddata got=%h exp=%h", MEM_LoadData, exp_last_load); end
        checks++; if (dc_req_valid !== 1'b0 || MEM_Stall !== 1'b1) begin
            failures++; $display("FAIL flush_idle got valid=%b stall=%b exp valid=0 stall=1", dc_req_valid, MEM_Stall); end
        @(negedge clk); #1;
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h500) begin
            failures++; $display("FAIL flush_next_req got valid=%b addr=%h exp valid=1 addr=00000500", dc_req_valid, dc_req_addr); end
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0; WB_Wr = 1'b1; MEM_StoreType = ST_NONE;
        @(negedge clk);
        WB_Wr = 1'b0;
        $display("txn flush_wait loaddata=%h", MEM_LoadData);
    endtask

    task automatic test_done_flush();
        @(negedge clk);
        MEM_StoreType = ST_SW; MEM_LoadType = LT_NONE; MEM_ALUOut = 32'h700; MEM_OutB = 32'h11; dc_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (MEM_Stall !== 1'b0) begin failures++; $display("FAIL done_stall got=%b exp=0", MEM_Stall); end
        MEM_Flush = 1'b1; WB_Wr = 1'b1; dc_req_ready = 1'b0;
        @(negedge clk);
        MEM_Flush = 1'b0; WB_Wr = 1'b0;
        MEM_StoreType = ST_SH; MEM_ALUOut = 32'h702; MEM_OutB = 32'hFFFF1234;
        #1;
        checks++; if (MEM_Stall !== 1'b1) begin failures++; $display("FAIL done_to_idle got stall=%b exp=1", MEM_Stall); end
        @(negedge clk); #1;
        checks++; if (dc_req_valid !== 1'b1 || dc_req_wstrb !== 4'b1100 || dc_req_wdata !== 32'h12341234) begin
            failures++; $display("FAIL sh_req got valid=%b strb=%b wdata=%h exp 1/1100/12341234", dc_req_valid, dc_req_wstrb, dc_req_wdata); end
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0; WB_Wr = 1'b1; MEM_StoreType = ST_NONE;
        @(negedge clk);
        WB_Wr = 1'b0;
        $display("txn done_flush then sh addr=00000702");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        MEM_LoadType = LT_LW; MEM_ALUOut = 32'h600; dc_req_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (dc_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", dc_req_valid); end
        MEM_LoadType = LT_NONE; rst = 1'b1;
        #1;
        checks++; if (dc_req_valid !== 1'b0 || MEM_Stall !== 1'b0 || dc_req_addr !== 32'd0 || MEM_LoadData !== 32'd0) begin
            failures++; $display("FAIL rstmid_clear got valid=%b stall=%b addr=%h data=%h exp all 0",
                                 dc_req_valid, MEM_Stall, dc_req_addr, MEM_LoadData); end
        @(negedge clk);
        rst = 1'b0;
        exp_last_load = 32'd0;
        $display("txn reset_mid");
    endtask

    task automatic test_random();
        obs_t        o;
        int          kind, rw, sw;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] a, d, raw;
        logic        misal;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            lt = (kind < 5) ? 3'(kind + 1) : 3'(LT_NONE);
            st = (kind < 5) ? 2'(ST_NONE) : 2'(kind - 4);
            a = $urandom; d = $urandom; raw = $urandom;
            rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
`ifdef MEM_ADDR_CHECK_EN
            misal = ref_misal(lt, st, a);
`else
            misal = 1'b0;
`endif
            drive_op(lt, st, a, d, raw, rw, sw, o);
            $display("txn rnd%0d lt=%0d st=%0d a=%h d=%h raw=%h rdy=%0d resp=%0d stall=%0d ld=%h",
                     n, lt, st, a, d, raw, rw, sw, o.stall_cycles, o.ld);
            if (misal) begin
                checks++; if (o.valid_cycles !== 0 || o.adexc !== 1'b1 || o.stall_cycles !== 1) begin
                    failures++; $display("FAIL rnd%0d_misal got valid=%0d adexc=%b stall=%0d exp 0/1/1",
                                         n, o.valid_cycles, o.adexc, o.stall_cycles); end
                continue;
            end
            checks++; if (o.addr !== (a & 32'hFFFF_FFFC) || o.wr !== (st != ST_NONE) ||
                          o.strb !== ref_wstrb(st, a) || o.stable !== 1'b1) begin
                failures++; $display("FAIL rnd%0d_req got addr=%h wr=%b strb=%b stable=%b exp addr=%h strb=%b",
                                     n, o.addr, o.wr, o.strb, o.stable, a & 32'hFFFF_FFFC, ref_wstrb(st, a)); end
            checks++; if (o.stall_cycles !== (1 + (rw + 1) + ((st == ST_NONE) ? sw + 1 : 0)) || o.adexc !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_stall got=%0d adexc=%b exp=%0d", n, o.stall_cycles, o.adexc,
                                     1 + (rw + 1) + ((st == ST_NONE) ? sw + 1 : 0)); end
            if (st != ST_NONE) begin
                checks++; if (o.wdata !== ref_wdata(st, d)) begin
                    failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o.wdata, ref_wdata(st, d)); end
            end else begin
                exp_last_load = ref_load(lt, a, raw);
                checks++; if (o.ld !== exp_last_load) begin
                    failures++; $display("FAIL rnd%0d_load got=%h exp=%h", n, o.ld, exp_last_load); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_ready_stall();
        test_store_byte();
        test_addr_check();
        test_flush_wait();
        test_done_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
